// File: rtl/manta_pkg.sv
// Shared definitions for the daisy-chained register bus and its UART bridge.
package manta_pkg;

  localparam int BUS_DATA_WIDTH = 16;
  localparam int BUS_ADDR_WIDTH = 16;

  localparam logic [7:0] PREAMBLE = 8'h4D;
  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;

  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_DATA_WIDTH-1:0] wdata;
    logic [BUS_DATA_WIDTH-1:0] rdata;
    logic                      rw;
    logic                      valid;
  } bus_txn_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: storage, wrap-bit pointers, full/empty/count,
// plus a look-ahead of the head entry as it will be after this cycle's push/pop.
module sync_fifo #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DEPTH      = 16,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int PTR_W      = ADDR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_W-1:0]      count,
  output logic                  next_empty,
  output logic [DATA_WIDTH-1:0] next_head
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr_nxt;

  assign wr_ptr_nxt = wr_ptr + PTR_W'(push);
  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign next_empty = (wr_ptr_nxt == rd_ptr_nxt);

  // The new head may be the word being written this very cycle, so bypass it.
  assign next_head = (push && (rd_ptr_nxt == wr_ptr)) ? wdata
                                                      : mem[rd_ptr_nxt[ADDR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= wr_ptr_nxt - rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/bus_resp_fifo.sv
// Read-response buffer between the register bus and bridge_tx: filters reads,
// queues them, and presents the head through a registered FWFT stage.
module bus_resp_fifo
  import manta_pkg::*;
#(
  parameter  int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter  int DEPTH      = 16,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [CNT_W-1:0]      count_o,
  output logic                  overflow_o,
  input  logic                  ovf_clr_i
);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_next_empty;
  logic [DATA_WIDTH-1:0] fifo_next_head;
  logic                  is_read;
  logic                  push;
  logic                  pop;
  logic                  ovf_set;

  assign is_read = valid_i && !rw_i;
  assign pop     = valid_o && !fifo_empty && ready_i;
  assign push    = is_read && (!fifo_full || pop);
  assign ovf_set = is_read && fifo_full && !pop;
  assign rw_o    = 1'b0;

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .wdata      (rdata_i),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count_o),
    .next_empty (fifo_next_empty),
    .next_head  (fifo_next_head)
  );

  // Output register tracks the head one edge ahead; rdata_o holds its last value once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o    <= 1'b0;
      rdata_o    <= '0;
      overflow_o <= 1'b0;
    end else begin
      valid_o <= !fifo_next_empty;
      if (!fifo_next_empty) begin
        rdata_o <= fifo_next_head;
      end
      if (ovf_set) begin
        overflow_o <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bus_resp_fifo.sv
// Self-checking bench for bus_resp_fifo: directed scenarios plus random traffic
// compared each cycle against a queue-based model of the response buffer.
module tb_bus_resp_fifo;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst_n;
  logic [15:0] rdata_i;
  logic        rw_i;
  logic        valid_i;
  logic [15:0] rdata_o;
  logic        rw_o;
  logic        valid_o;
  logic        ready_i;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic        ovf_clr_i;

  int checks;
  int errors;

  logic [15:0] mq [$];
  logic        movf;

  bus_resp_fifo #(
    .DATA_WIDTH (16),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdata_i    (rdata_i),
    .rw_i       (rw_i),
    .valid_i    (valid_i),
    .rdata_o    (rdata_o),
    .rw_o       (rw_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .count_o    (count_o),
    .overflow_o (overflow_o),
    .ovf_clr_i  (ovf_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compareAll(input string tag);
    checkOutput({tag, ".valid"}, 32'(valid_o), 32'(mq.size() != 0));
    checkOutput({tag, ".count"}, 32'(count_o), 32'(mq.size()));
    checkOutput({tag, ".ovf"}, 32'(overflow_o), 32'(movf));
    checkOutput({tag, ".rw"}, 32'(rw_o), 32'd0);
    if (mq.size() != 0) checkOutput({tag, ".rdata"}, 32'(rdata_o), 32'(mq[0]));
  endtask

  // One bus cycle: drive at negedge, advance the model, check just after posedge.
  task automatic applyStimulus(input string tag, input logic v, input logic rw,
                               input logic [15:0] d, input logic rdy, input logic clr);
    logic mpop, mpush, mset;
    @(negedge clk);
    valid_i   = v;
    rw_i      = rw;
    rdata_i   = d;
    ready_i   = rdy;
    ovf_clr_i = clr;
    mpop  = (mq.size() != 0) && rdy;
    mpush = v && !rw && ((mq.size() < DEPTH) || mpop);
    mset  = v && !rw && (mq.size() == DEPTH) && !mpop;
    if (mpop) void'(mq.pop_front());
    if (mpush) mq.push_back(d);
    if (mset) movf = 1'b1;
    else if (clr) movf = 1'b0;
    @(posedge clk);
    #1;
    compareAll(tag);
    valid_i   = 1'b0;
    rw_i      = 1'b0;
    ready_i   = 1'b0;
    ovf_clr_i = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    movf      = 1'b0;
    rst_n     = 1'b0;
    rdata_i   = '0;
    rw_i      = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    ovf_clr_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.valid", 32'(valid_o), 32'd0);
    checkOutput("rst.count", 32'(count_o), 32'd0);
    checkOutput("rst.rdata", 32'(rdata_o), 32'd0);
    checkOutput("rst.ovf", 32'(overflow_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read, immediately accepted
    applyStimulus("t1.push", 1'b1, 1'b0, 16'hBEEF, 1'b1, 1'b0);
    checkOutput("t1.head", 32'(rdata_o), 32'h0000BEEF);
    applyStimulus("t1.pop", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Writes never queue
    applyStimulus("t2.write", 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus("t2.idle", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Slow consumer: held head, strict order
    for (int i = 1; i <= 3; i++) applyStimulus("t3.fill", 1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 6; j++) applyStimulus("t3.hold", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
      applyStimulus("t3.pop", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end

    // Overfill, set-beats-clear, then clear
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus("t4.fill", 1'b1, 1'b0, 16'(i), 1'b0, 1'b0);
    checkOutput("t4.full", 32'(count_o), 32'd16);
    checkOutput("t4.ovf", 32'(overflow_o), 32'd1);
    applyStimulus("t4.setwins", 1'b1, 1'b0, 16'hDEAD, 1'b0, 1'b1);
    applyStimulus("t4.clr", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("t4.ovfclr", 32'(overflow_o), 32'd0);

    // Push and pop together while full
    applyStimulus("t5.pushpop", 1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0);
    checkOutput("t5.count", 32'(count_o), 32'd16);
    for (int i = 0; i < DEPTH; i++) applyStimulus("t5.drain", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Count-1 replace without a bubble
    applyStimulus("t5b.one", 1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
    applyStimulus("t5b.swap", 1'b1, 1'b0, 16'h2222, 1'b1, 1'b0);
    applyStimulus("t5b.pop", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle with entries queued
    for (int i = 0; i < 5; i++) applyStimulus("t6.fill", 1'b1, 1'b0, 16'h0C00 + 16'(i), 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    mq.delete();
    movf = 1'b0;
    checkOutput("t6.rst.valid", 32'(valid_o), 32'd0);
    checkOutput("t6.rst.count", 32'(count_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("t6.new", 1'b1, 1'b0, 16'h5A5A, 1'b0, 1'b0);
    checkOutput("t6.newdata", 32'(rdata_o), 32'h00005A5A);
    applyStimulus("t6.pop", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      applyStimulus("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    16'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end
    for (int n = 0; n < DEPTH + 2; n++) applyStimulus("rnd.drain", 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
